// File: rtl/ddr_dly_ctrl_pkg.sv
// Shared types for the DDR address/command delay-line tap controller.
package ddr_dly_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_INC  = 2'b01,
      OP_DEC  = 2'b10,
      OP_SET  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_OK    = 2'b00,
      ST_OOR   = 2'b01,
      ST_LIMIT = 2'b10,
      ST_BAD   = 2'b11
   } status_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_LOAD,
      S_MOVE,
      S_WAIT,
      S_DONE
   } state_t;

   // Write operations on the per-lane tap count bank.
   typedef enum logic [1:0] {
      BK_NONE,
      BK_INC,
      BK_DEC,
      BK_CLR
   } bank_op_t;

endpackage

// File: rtl/ddr_dly_tap_bank.sv
// Per-lane tap count register file: one +1/-1/clear write port, two
// combinational read ports returning 0 for lanes outside the bank.
module ddr_dly_tap_bank
   import ddr_dly_ctrl_pkg::*;
#(
   parameter int NUM_LANES = 8,
   parameter int TAP_W     = 8,
   parameter int LANE_W    = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  bank_op_t          wr_op,
   input  logic [LANE_W-1:0] wr_lane,
   input  logic [LANE_W-1:0] rd_a_lane,
   output logic [TAP_W-1:0]  rd_a_data,
   input  logic [LANE_W-1:0] rd_b_lane,
   output logic [TAP_W-1:0]  rd_b_data
);

   localparam logic [LANE_W:0] LANE_LIM = (LANE_W+1)'(NUM_LANES);

   logic [TAP_W-1:0] cnt [NUM_LANES];

   // Tap count update: reset clears all lanes, otherwise one lane per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '{default: '0};
      end else begin
         case (wr_op)
            BK_INC:  cnt[wr_lane] <= cnt[wr_lane] + TAP_W'(1);
            BK_DEC:  cnt[wr_lane] <= cnt[wr_lane] - TAP_W'(1);
            BK_CLR:  cnt[wr_lane] <= '0;
            default: ;
         endcase
      end
   end

   // Range-checked combinational readback on both ports.
   always_comb begin
      rd_a_data = '0;
      rd_b_data = '0;
      if ({1'b0, rd_a_lane} < LANE_LIM) rd_a_data = cnt[rd_a_lane];
      if ({1'b0, rd_b_lane} < LANE_LIM) rd_b_data = cnt[rd_b_lane];
   end

endmodule

// File: rtl/ddr_ca_dly_tap_ctrl.sv
// Sequences LOAD/MOVE/DIRECTION strobes of the CA IOD delay lines for one
// tap request at a time, tracking per-lane tap counts and range limits.
module ddr_ca_dly_tap_ctrl
   import ddr_dly_ctrl_pkg::*;
#(
   parameter int   NUM_LANES  = 8,
   parameter int   TAP_W      = 8,
   parameter int   MAX_TAP    = 255,
   parameter int   SETTLE_CYC = 3,
   localparam int  LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic                 FAB_CLK,
   input  logic                 SYNC_RST,
   input  logic                 REQ_VALID,
   output logic                 REQ_READY,
   input  logic [LANE_W-1:0]    REQ_LANE,
   input  logic [1:0]           REQ_OP,
   input  logic [TAP_W-1:0]     REQ_TAP,
   output logic                 DONE_VALID,
   output logic [1:0]           DONE_STATUS,
   output logic [TAP_W-1:0]     DONE_TAP,
   output logic [NUM_LANES-1:0] DELAY_LINE_LOAD,
   output logic [NUM_LANES-1:0] DELAY_LINE_MOVE,
   output logic [NUM_LANES-1:0] DELAY_LINE_DIRECTION,
   input  logic [NUM_LANES-1:0] DELAY_LINE_OUT_OF_RANGE,
   input  logic [LANE_W-1:0]    TAP_RD_LANE,
   output logic [TAP_W-1:0]     TAP_RD_DATA
);

   localparam logic [LANE_W:0]  LANE_LIM  = (LANE_W+1)'(NUM_LANES);
   localparam logic [TAP_W-1:0] TAP_MAX   = TAP_W'(MAX_TAP);
   localparam logic [3:0]       WAIT_LAST = 4'(SETTLE_CYC - 1);

   state_t              state, state_nxt;
   logic [LANE_W-1:0]   lane_q;
   op_t                 op_q;
   logic                dir_q;
   logic [TAP_W-1:0]    steps_q;
   logic                bad_q;
   logic [3:0]          wait_q;
   logic [NUM_LANES-1:0] dir_line;
   status_t             done_status_q;
   logic [TAP_W-1:0]    done_tap_q;

   logic [LANE_W-1:0]   cur_lane;
   logic [TAP_W-1:0]    cur_tap;
   bank_op_t            bank_op;

   logic                accept;
   op_t                 req_op;
   logic                req_bad;
   logic                req_dir;
   logic [TAP_W-1:0]    req_steps;
   logic                at_limit;
   logic                wait_last;
   logic                oor;
   status_t             fin_status;
   logic [TAP_W-1:0]    fin_tap;
   logic [NUM_LANES-1:0] lane_onehot;

   // In IDLE the bank is read at the requested lane so SET can size its move.
   assign cur_lane = (state == S_IDLE) ? REQ_LANE : lane_q;

   ddr_dly_tap_bank #(
      .NUM_LANES (NUM_LANES),
      .TAP_W     (TAP_W),
      .LANE_W    (LANE_W)
   ) u_bank (
      .clk       (FAB_CLK),
      .rst       (SYNC_RST),
      .wr_op     (bank_op),
      .wr_lane   (lane_q),
      .rd_a_lane (cur_lane),
      .rd_a_data (cur_tap),
      .rd_b_lane (TAP_RD_LANE),
      .rd_b_data (TAP_RD_DATA)
   );

   // Request decode: validity, direction and step count at acceptance.
   always_comb begin
      req_op    = op_t'(REQ_OP);
      req_bad   = ({1'b0, REQ_LANE} >= LANE_LIM) ||
                  (req_op == OP_SET && REQ_TAP > TAP_MAX);
      req_dir   = 1'b0;
      req_steps = '0;
      case (req_op)
         OP_INC: begin
            req_dir   = 1'b1;
            req_steps = REQ_TAP;
         end
         OP_DEC: begin
            req_dir   = 1'b0;
            req_steps = REQ_TAP;
         end
         OP_SET: begin
            req_dir   = (REQ_TAP > cur_tap);
            req_steps = req_dir ? (REQ_TAP - cur_tap) : (cur_tap - REQ_TAP);
         end
         default: ;
      endcase
   end

   assign accept    = REQ_VALID && REQ_READY;
   assign at_limit  = dir_q ? (cur_tap == TAP_MAX) : (cur_tap == '0);
   assign wait_last = (wait_q == '0);
   assign oor       = DELAY_LINE_OUT_OF_RANGE[lane_q];

   // State register.
   always_ff @(posedge FAB_CLK) begin
      if (SYNC_RST) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state, bank write and completion result selection.
   always_comb begin
      state_nxt  = state;
      bank_op    = BK_NONE;
      fin_status = ST_OK;
      fin_tap    = cur_tap;
      case (state)
         S_IDLE: if (accept) state_nxt = S_SETUP;
         S_SETUP: begin
            if (bad_q) begin
               fin_status = ST_BAD;
               state_nxt  = S_DONE;
            end else if (op_q == OP_LOAD) begin
               state_nxt = S_LOAD;
            end else if (steps_q == '0) begin
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_MOVE;
            end
         end
         S_MOVE: begin
            if (at_limit) begin
               fin_status = ST_LIMIT;
               state_nxt  = S_DONE;
            end else begin
               bank_op   = dir_q ? BK_INC : BK_DEC;
               state_nxt = S_WAIT;
            end
         end
         S_LOAD: begin
            bank_op   = BK_CLR;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (wait_last) begin
               if (oor) begin
                  fin_status = ST_OOR;
                  state_nxt  = S_DONE;
                  if (op_q != OP_LOAD) begin
                     bank_op = dir_q ? BK_DEC : BK_INC;
                     fin_tap = dir_q ? (cur_tap - TAP_W'(1)) : (cur_tap + TAP_W'(1));
                  end
               end else if (steps_q != '0) begin
                  state_nxt = S_MOVE;
               end else begin
                  state_nxt = S_DONE;
               end
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Request latch, step/settle counters, direction lines and DONE result.
   // The direction bit is written at acceptance so it is already valid in
   // SETUP, one cycle ahead of the first MOVE pulse.
   always_ff @(posedge FAB_CLK) begin
      if (SYNC_RST) begin
         lane_q        <= '0;
         op_q          <= OP_LOAD;
         dir_q         <= 1'b0;
         steps_q       <= '0;
         bad_q         <= 1'b0;
         wait_q        <= '0;
         dir_line      <= '0;
         done_status_q <= ST_OK;
         done_tap_q    <= '0;
      end else begin
         if (accept) begin
            lane_q  <= REQ_LANE;
            op_q    <= req_op;
            dir_q   <= req_dir;
            steps_q <= req_steps;
            bad_q   <= req_bad;
            if (!req_bad && req_op != OP_LOAD && req_steps != '0)
               dir_line[REQ_LANE] <= req_dir;
         end
         if (state == S_MOVE && !at_limit) begin
            steps_q <= steps_q - TAP_W'(1);
            wait_q  <= WAIT_LAST;
         end
         if (state == S_LOAD) wait_q <= WAIT_LAST;
         if (state == S_WAIT && !wait_last) wait_q <= wait_q - 4'd1;
         if (state_nxt == S_DONE) begin
            done_status_q <= fin_status;
            done_tap_q    <= fin_tap;
         end
      end
   end

   // Strobe and handshake outputs decoded from the current state.
   always_comb begin
      lane_onehot     = NUM_LANES'(1) << lane_q;
      REQ_READY       = (state == S_IDLE) && !SYNC_RST;
      DONE_VALID      = (state == S_DONE);
      DELAY_LINE_LOAD = '0;
      DELAY_LINE_MOVE = '0;
      if (state == S_LOAD)              DELAY_LINE_LOAD = lane_onehot;
      if (state == S_MOVE && !at_limit) DELAY_LINE_MOVE = lane_onehot;
   end

   assign DELAY_LINE_DIRECTION = dir_line;
   assign DONE_STATUS          = done_status_q;
   assign DONE_TAP             = done_tap_q;

endmodule

// File: tb/tb_ddr_ca_dly_tap_ctrl.sv
// Self-checking bench for ddr_ca_dly_tap_ctrl: directed and random tap
// requests checked against an arithmetic model of counts, timing and status.
module tb_ddr_ca_dly_tap_ctrl;

   localparam int NL   = 6;
   localparam int TW   = 8;
   localparam int MAXT = 250;
   localparam int S    = 3;
   localparam int LW   = 3;

   logic          FAB_CLK = 1'b0;
   logic          SYNC_RST;
   logic          REQ_VALID;
   logic          REQ_READY;
   logic [LW-1:0] REQ_LANE;
   logic [1:0]    REQ_OP;
   logic [TW-1:0] REQ_TAP;
   logic          DONE_VALID;
   logic [1:0]    DONE_STATUS;
   logic [TW-1:0] DONE_TAP;
   logic [NL-1:0] DELAY_LINE_LOAD;
   logic [NL-1:0] DELAY_LINE_MOVE;
   logic [NL-1:0] DELAY_LINE_DIRECTION;
   logic [NL-1:0] DELAY_LINE_OUT_OF_RANGE;
   logic [LW-1:0] TAP_RD_LANE;
   logic [TW-1:0] TAP_RD_DATA;

   int            n_assert = 0;
   int            n_fail   = 0;
   int            tapm [NL];
   logic [NL-1:0] dirm;

   ddr_ca_dly_tap_ctrl #(
      .NUM_LANES  (NL),
      .TAP_W      (TW),
      .MAX_TAP    (MAXT),
      .SETTLE_CYC (S)
   ) dut (
      .FAB_CLK                 (FAB_CLK),
      .SYNC_RST                (SYNC_RST),
      .REQ_VALID               (REQ_VALID),
      .REQ_READY               (REQ_READY),
      .REQ_LANE                (REQ_LANE),
      .REQ_OP                  (REQ_OP),
      .REQ_TAP                 (REQ_TAP),
      .DONE_VALID              (DONE_VALID),
      .DONE_STATUS             (DONE_STATUS),
      .DONE_TAP                (DONE_TAP),
      .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
      .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
      .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
      .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
      .TAP_RD_LANE             (TAP_RD_LANE),
      .TAP_RD_DATA             (TAP_RD_DATA)
   );

   always #5 FAB_CLK = ~FAB_CLK;

   initial begin
      #2ms;
      $display("FAIL watchdog: observed no end of test, expected end before 2ms");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // One request end to end: model the outcome, drive it, watch every cycle
   // until DONE, then check counts, timing, readback and the idle cycle after.
   task automatic run_req(input int lane, input int op, input int tv, input int oor_p);
      int            bad, dir, steps, n, t, cyc, pulses, done_cyc, rl;
      int            ex_pulses, ex_status, ex_tap, ex_done;
      logic          oor_on;
      logic [NL-1:0] lmask, strobes;

      bad   = (lane >= NL) || (op == 3 && tv > MAXT);
      t     = (lane < NL) ? tapm[lane] : 0;
      dir   = 0;
      steps = 0;
      if (op == 1) begin
         dir = 1; steps = tv;
      end else if (op == 2) begin
         dir = 0; steps = tv;
      end else if (op == 3) begin
         dir   = (tv > t) ? 1 : 0;
         steps = (tv > t) ? tv - t : t - tv;
      end
      if (bad) begin
         ex_status = 3; ex_pulses = 0; ex_tap = t; ex_done = 2;
      end else if (op == 0) begin
         ex_status = (oor_p == 1) ? 1 : 0; ex_pulses = 1; ex_tap = 0; ex_done = 3 + S;
      end else if (steps == 0) begin
         ex_status = 0; ex_pulses = 0; ex_tap = t; ex_done = 2;
      end else begin
         n = dir ? MAXT - t : t;
         if (steps < n) n = steps;
         if (oor_p >= 1 && oor_p <= n) begin
            ex_status = 1; ex_pulses = oor_p;
            ex_tap    = dir ? t + oor_p - 1 : t - oor_p + 1;
            ex_done   = 2 + oor_p * (1 + S);
         end else if (n < steps) begin
            ex_status = 2; ex_pulses = n;
            ex_tap    = dir ? t + n : t - n;
            ex_done   = 3 + n * (1 + S);
         end else begin
            ex_status = 0; ex_pulses = n;
            ex_tap    = dir ? t + n : t - n;
            ex_done   = 2 + n * (1 + S);
         end
         dirm[lane] = dir[0];
      end
      if (!bad) tapm[lane] = ex_tap;

      lmask  = (lane < NL) ? (NL'(1) << lane) : '0;
      oor_on = 1'b0;
      @(negedge FAB_CLK);
      check("req_ready_idle", REQ_READY, 1);
      REQ_VALID = 1'b1;
      REQ_LANE  = LW'(lane);
      REQ_OP    = 2'(op);
      REQ_TAP   = TW'(tv);
      @(posedge FAB_CLK);
      #1;
      REQ_VALID = 1'b0;
      REQ_LANE  = LW'($urandom);
      REQ_OP    = 2'($urandom);
      REQ_TAP   = TW'($urandom);
      cyc       = 1;
      pulses    = 0;
      done_cyc  = -1;
      check("dir_in_setup", DELAY_LINE_DIRECTION, dirm);
      while (done_cyc < 0 && cyc < 3000) begin
         strobes = DELAY_LINE_LOAD | DELAY_LINE_MOVE;
         if (strobes != '0) begin
            pulses++;
            check("strobe_lane", strobes, lmask);
            check("strobe_is_load", DELAY_LINE_LOAD != '0, op == 0);
            check("strobe_is_move", DELAY_LINE_MOVE != '0, op != 0);
            check("pulse_cycle", cyc, 2 + (pulses - 1) * (1 + S));
            if (op != 0 && lane < NL) check("dir_at_move", DELAY_LINE_DIRECTION[lane], dir);
            if (pulses == oor_p) oor_on = 1'b1;
         end
         if (DONE_VALID) begin
            done_cyc = cyc;
            check("done_status", DONE_STATUS, ex_status);
            if (lane < NL) check("done_tap", DONE_TAP, ex_tap);
         end else begin
            @(posedge FAB_CLK);
            #1;
            cyc++;
            DELAY_LINE_OUT_OF_RANGE = (NL'($urandom) & ~lmask) | (oor_on ? lmask : '0);
         end
      end
      check("done_cycle", done_cyc, ex_done);
      check("pulse_count", pulses, ex_pulses);

      @(posedge FAB_CLK);
      #1;
      DELAY_LINE_OUT_OF_RANGE = '0;
      check("done_one_cycle", DONE_VALID, 0);
      check("ready_after_done", REQ_READY, 1);
      check("status_held", DONE_STATUS, ex_status);
      check("dir_vector", DELAY_LINE_DIRECTION, dirm);
      if (lane < NL) begin
         check("done_tap_held", DONE_TAP, ex_tap);
         TAP_RD_LANE = LW'(lane);
         #1;
         check("tap_rd_lane", TAP_RD_DATA, ex_tap);
      end
      rl          = $urandom_range(0, 7);
      TAP_RD_LANE = LW'(rl);
      #1;
      check("tap_rd_any", TAP_RD_DATA, (rl < NL) ? tapm[rl] : 0);
   endtask

   initial begin
      int lane, op, tv, oor_p;

      SYNC_RST                = 1'b1;
      REQ_VALID               = 1'b0;
      REQ_LANE                = '0;
      REQ_OP                  = '0;
      REQ_TAP                 = '0;
      DELAY_LINE_OUT_OF_RANGE = '0;
      TAP_RD_LANE             = '0;
      for (int i = 0; i < NL; i++) tapm[i] = 0;
      dirm = '0;

      repeat (3) @(posedge FAB_CLK);
      #1;
      check("rst_ready_low", REQ_READY, 0);
      check("rst_done_valid", DONE_VALID, 0);
      check("rst_strobes", DELAY_LINE_LOAD | DELAY_LINE_MOVE, 0);
      @(negedge FAB_CLK);
      SYNC_RST = 1'b0;
      @(posedge FAB_CLK);
      #1;
      check("post_rst_ready", REQ_READY, 1);
      check("post_rst_status", DONE_STATUS, 0);
      check("post_rst_tap", DONE_TAP, 0);
      check("post_rst_dir", DELAY_LINE_DIRECTION, 0);

      // Directed cases
      run_req(2, 0, 0, 0);
      for (int l = 0; l < NL; l++) if (l != 2) run_req(l, 0, 0, 0);
      run_req(0, 1, 4, 0);
      run_req(0, 3, 1, 0);
      run_req(0, 3, 1, 0);
      run_req(1, 3, MAXT - 2, 0);
      run_req(1, 1, 5, 0);
      run_req(3, 1, 3, 2);
      run_req(7, 1, 3, 0);
      run_req(0, 3, MAXT + 1, 0);
      run_req(4, 2, 1, 0);
      run_req(5, 0, 0, 1);
      run_req(5, 1, 2, 0);

      // Random requests
      for (int k = 0; k < 25; k++) begin
         lane  = $urandom_range(0, 7);
         op    = $urandom_range(0, 3);
         tv    = (op == 3) ? $urandom_range(0, 255) : $urandom_range(0, 10);
         oor_p = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
         run_req(lane, op, tv, oor_p);
      end

      // Reset in the middle of an INC's settle window
      @(negedge FAB_CLK);
      REQ_VALID = 1'b1;
      REQ_LANE  = LW'(2);
      REQ_OP    = 2'(1);
      REQ_TAP   = TW'(4);
      @(posedge FAB_CLK);
      #1;
      REQ_VALID = 1'b0;
      @(posedge FAB_CLK);
      #1;
      check("mid_move_pulse", DELAY_LINE_MOVE, 6'b000100);
      @(posedge FAB_CLK);
      #1;
      @(negedge FAB_CLK);
      SYNC_RST = 1'b1;
      @(posedge FAB_CLK);
      #1;
      check("midrst_strobes", DELAY_LINE_LOAD | DELAY_LINE_MOVE, 0);
      check("midrst_dir", DELAY_LINE_DIRECTION, 0);
      check("midrst_done", DONE_VALID, 0);
      check("midrst_ready_low", REQ_READY, 0);
      @(negedge FAB_CLK);
      SYNC_RST = 1'b0;
      for (int i = 0; i < NL; i++) tapm[i] = 0;
      dirm = '0;
      @(posedge FAB_CLK);
      #1;
      check("midrst_ready_high", REQ_READY, 1);
      for (int l = 0; l < NL; l++) begin
         TAP_RD_LANE = LW'(l);
         #1;
         check("midrst_tap_zero", TAP_RD_DATA, 0);
      end
      for (int c = 0; c < 8; c++) begin
         @(posedge FAB_CLK);
         #1;
         check("midrst_no_done", DONE_VALID, 0);
         check("midrst_quiet", DELAY_LINE_LOAD | DELAY_LINE_MOVE, 0);
      end

      run_req(2, 0, 0, 0);
      run_req(2, 1, 2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
